fetch_stage: RTL and testbench

//  Instruction fetch stage; sits directly upstream of decode and supplies it 32-bit instructions.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and fetch-stage types.
// Imported by the fetch stage, its FIFO users and the fetch bus interface.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and decode handoff.
// master = fetch stage side, slave = memory/decode side.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head entry is visible combinationally.
// A push is accepted when full if a pop happens in the same cycle.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;
  T              entries [DEPTH];

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);
  assign head    = entries[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entries are cleared on reset so an empty queue presents all-zero outputs.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    T entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (do_push && !flush && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entries[gi] = entry_reg;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and queues results for decode.
// Define FETCH_STATS_EN to add the stat_fetched / stat_stall counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_stall,
`endif
  fetch_stage_if.master   bus
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_e    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   discard_reg;
  logic [CW-1:0]   discard_next;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   pf_count;
  logic [CW:0]     occupancy;
  logic            grant;
  logic            rsp;
  logic            accept;
  logic            deliver;
  fq_entry_t       q_head;
  fq_entry_t       q_push_data;
  logic [XLEN-1:0] pf_head;

  // Queued words plus in-flight requests never exceed the queue depth, so no response can overflow it.
  assign occupancy     = {1'b0, q_count} + {1'b0, outstanding_reg};
  assign bus.imem_req  = (state_reg == RUN) && (occupancy < (CW+1)'(FQ_DEPTH)) && !redirect_valid;
  assign bus.imem_addr = pc_reg;

  assign grant   = bus.imem_req && bus.imem_gnt;
  assign rsp     = bus.imem_rvalid && (outstanding_reg != '0);
  assign accept  = rsp && (discard_reg == '0) && !redirect_valid;
  assign deliver = bus.instr_valid && bus.instr_ready;

  always_comb begin
    outstanding_next = outstanding_reg + CW'(grant) - CW'(rsp);
    discard_next     = discard_reg;
    pc_next          = pc_reg;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      discard_next = outstanding_next;
      pc_next      = word_align(redirect_pc);
    end else begin
      if (rsp && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
      if (grant) pc_next = pc_reg + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      unique case (state_reg)
        BOOT:    state_reg <= RUN;
        RUN:     if (redirect_valid && (discard_next != '0)) state_reg <= DRAIN;
        DRAIN:   if (discard_next == '0) state_reg <= RUN;
        default: state_reg <= BOOT;
      endcase
    end
  end

  assign q_push_data = '{instr: bus.imem_rdata, pc: pf_head};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (fq_entry_t)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (q_push_data),
    .pop       (deliver),
    .head      (q_head),
    .count     (q_count)
  );

  // The PC FIFO is flushed on redirect; discarded responses never pop it.
  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (grant),
    .push_data (pc_reg),
    .pop       (accept),
    .head      (pf_head),
    .count     (pf_count)
  );

  assign bus.instr_valid = (q_count != '0);
  assign bus.instr       = q_head.instr;
  assign bus.instr_pc    = q_head.pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (deliver) stat_fetched <= stat_fetched + 32'd1;
      if ((state_reg != BOOT) && !bus.instr_valid) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> (outstanding_reg != '0));

  a_pc_fifo_tracks: assert property (@(posedge clk) disable iff (!rst_n)
    (discard_reg == '0) |-> (pf_count == outstanding_reg));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one-cycle-latency memory model plus a PC-order scoreboard.
// Delivered words are expected to equal ~pc of the fetched address.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched   (stat_fetched),
    .stat_stall     (stat_stall),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          first_valid = -1;
  int          n_hs = 0;
  int          hs0;
  int          tries;
  logic        gnt_en, rsp_en, ready, redir;
  logic [31:0] redir_target;
  logic [31:0] exp_pc;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  logic [31:0] rsp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the negedge, sample 1 time unit later, then wait for the next negedge.
  task automatic step();
    logic rv;
    rv = rsp_en && (rsp_q.size() != 0);
    bus.imem_gnt    = gnt_en;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? ~rsp_q[0] : 32'h0;
    bus.instr_ready = ready;
    redirect_valid  = redir;
    redirect_pc     = redir_target;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.instr_valid;
    if (s_valid && (first_valid < 0)) first_valid = cyc;
    if (bus.instr_valid && bus.instr_ready) begin
      $display("cyc %0d: decode took pc %h instr %h", cyc, bus.instr_pc, bus.instr);
      check("instr_pc", bus.instr_pc, exp_pc);
      check("instr", bus.instr, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_hs++;
    end
    if (redir) exp_pc = redir_target & ~32'd3;
    if (rv) void'(rsp_q.pop_front());
    if (s_req && bus.imem_gnt) begin
      check("addr_align", s_addr & 32'd3, 32'd0);
      rsp_q.push_back(s_addr);
    end
    redir = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    gnt_en          = 1'b1;
    rsp_en          = 1'b1;
    ready           = 1'b1;
    redir           = 1'b0;
    redir_target    = 32'h0;
    exp_pc          = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", bus.imem_req, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", bus.instr_valid, 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Boot cycle, first request, first decode-valid on cycle 3.
    step(); check("boot_req", s_req, 32'd0);
    step(); check("run_req", s_req, 32'd1); check("run_addr", s_addr, 32'h0);
    step();
    step();
    check("first_valid_cyc", 32'(first_valid), 32'd3);

    // Grant withheld: address must hold at 0x8.
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_addr", s_addr, 32'h8);
      check("hold_req", s_req, 32'd1);
    end
    gnt_en = 1'b1;
    repeat (20) step();

    // Decode stall: queue fills, requests stop, nothing stays in flight.
    ready = 1'b0;
    repeat (10) step();
    check("stall_req", s_req, 32'd0);
    check("stall_valid", s_valid, 32'd1);
    check("stall_pending", 32'(rsp_q.size()), 32'd0);
    ready = 1'b1;
    repeat (10) step();

    // Redirect to 0x100 with two responses still outstanding.
    rsp_en = 1'b0;
    repeat (6) step();
    check("t4_pending", 32'(rsp_q.size()), 32'd2);
    check("t4_req_capped", s_req, 32'd0);
    redir = 1'b1; redir_target = 32'h100;
    step();
    rsp_en = 1'b1;
    step(); check("t4_drain_req1", s_req, 32'd0);
    step(); check("t4_drain_req2", s_req, 32'd0);
    step(); check("t4_new_req", s_req, 32'd1); check("t4_new_addr", s_addr, 32'h100);
    hs0 = n_hs;
    repeat (10) step();
    check("t4_progress", 32'(n_hs > hs0), 32'd1);

    // Redirect to 0x200 coinciding with a response and with gnt high.
    tries = 0;
    while ((rsp_q.size() == 0) && (tries < 10)) begin
      step();
      tries++;
    end
    check("t5_rsp_pending", 32'(rsp_q.size() != 0), 32'd1);
    redir = 1'b1; redir_target = 32'h200;
    step();
    check("t5_req_blocked", s_req, 32'd0);
    hs0 = n_hs;
    repeat (12) step();
    check("t5_progress", 32'(n_hs > hs0), 32'd1);

    // Unaligned redirect target with a full queue: queue flushed, address aligned.
    ready = 1'b0;
    repeat (4) step();
    check("t6_full_valid", s_valid, 32'd1);
    redir = 1'b1; redir_target = 32'h103;
    step();
    ready = 1'b1;
    step();
    check("t6_addr", s_addr, 32'h100);
    check("t6_valid_flushed", s_valid, 32'd0);
    hs0 = n_hs;
    repeat (12) step();
    check("t6_progress", 32'(n_hs > hs0), 32'd1);

`ifdef FETCH_STATS_EN
    $display("stats: fetched %0d stall %0d", stat_fetched, stat_stall);
    check("stat_fetched", stat_fetched, 32'(n_hs));
`endif

    // Asynchronous reset between clock edges clears state immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_req", bus.imem_req, 32'd0);
    check("areset_valid", bus.instr_valid, 32'd0);
    check("areset_addr", bus.imem_addr, 32'h0);
    check("areset_instr_pc", bus.instr_pc, 32'h0);
    rsp_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
